seq_shift_unit: RTL and testbench

//  Multi-cycle shift/rotate engine: performs the same shift/rotate operations as
//  the combinational barrel shifter, but moves one bit position per clock.

---
 rtl/shift_pkg.sv | 20 ++
 rtl/seq_shift_unit_if.sv | 31 +++
 rtl/shift_step.sv | 32 +++
 rtl/seq_shift_unit.sv | 86 ++++++++
 tb/tb_seq_shift_unit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared state encoding and command constants for the sequential shifter.
// Rev 1.0
`default_nettype none

package shift_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } shift_state_t;

   localparam logic SEL_SHIFT  = 1'b0;
   localparam logic SEL_ROTATE = 1'b1;
   localparam logic DIR_RIGHT  = 1'b0;
   localparam logic DIR_LEFT   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/seq_shift_unit_if.sv
// seq_shift_unit_if: operand/command and result handshake bundle.
// Rev 1.0
`default_nettype none

interface seq_shift_unit_if #(
   parameter int WIDTH = 4
) ();
   localparam int SHW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic             select;
   logic             direction;
   logic [SHW-1:0]   shift_value;
   logic [WIDTH-1:0] din;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] dout;

   modport master (
      output in_valid, select, direction, shift_value, din, out_ready,
      input  in_ready, out_valid, dout
   );

   modport slave (
      input  in_valid, select, direction, shift_value, din, out_ready,
      output in_ready, out_valid, dout
   );
endinterface

`default_nettype wire

// File: rtl/shift_step.sv
// shift_step: combinational one-position logical shift or rotate.
// Rev 1.0
`default_nettype none

module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  wire logic [WIDTH-1:0] d,
   input  wire logic             select,
   input  wire logic             direction,
   output logic      [WIDTH-1:0] q
);

   logic fill;

   always_comb begin
      fill = 1'b0;
      q    = d;
      if (direction == DIR_LEFT) begin
         fill = (select == SEL_SHIFT) ? 1'b0 : d[WIDTH-1];
         q    = {d[WIDTH-2:0], fill};
      end else begin
         fill = (select == SEL_ROTATE) ? d[0] : 1'b0;
         q    = {fill, d[WIDTH-1:1]};
      end
   end

endmodule

`default_nettype wire

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: bit-serial shift/rotate engine, one position per clock.
// Rev 1.0
`default_nettype none

module seq_shift_unit
   import shift_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   seq_shift_unit_if.slave bus
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] CNT_ZERO = '0;
   localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

   shift_state_t     state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d, step_q;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             sel_q, sel_d, dir_q, dir_d;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .d         (data_q),
      .select    (sel_q),
      .direction (dir_q),
      .q         (step_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         sel_q   <= 1'b0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         dir_q   <= dir_d;
      end
   end

   // Command fields are captured only on accept, so the producer may change them afterwards.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      dir_d   = dir_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               data_d  = bus.din;
               cnt_d   = bus.shift_value;
               sel_d   = bus.select;
               dir_d   = bus.direction;
               state_d = (bus.shift_value == CNT_ZERO) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            data_d = step_q;
            cnt_d  = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.dout      = data_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit: scoreboard bench with directed cases and random commands.
// Rev 1.0
`default_nettype none

module tb_seq_shift_unit;

   localparam int WIDTH = 4;
   localparam int SHW   = $clog2(WIDTH);

   typedef struct {
      logic [WIDTH-1:0] data;
      int               lat;
      int               acc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   vectors;
   int   miscompares;
   int   ready_mode;
   bit   seen;
   logic [WIDTH-1:0] cur_exp;
   exp_t sb[$];

   seq_shift_unit_if #(.WIDTH(WIDTH)) bus ();

   seq_shift_unit #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference: whole-word shift/rotate computed arithmetically.
   function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input logic sel,
                                              input logic dir, input int amt);
      int v;
      int r;
      logic [WIDTH-1:0] res;
      v = int'(d);
      if (amt == 0) r = v;
      else if (dir) r = (v << amt) | (sel ? (v >> (WIDTH - amt)) : 0);
      else          r = (v >> amt) | (sel ? (v << (WIDTH - amt)) : 0);
      res = r[WIDTH-1:0];
      return res;
   endfunction

   always begin
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       bus.out_ready = 1'b1;
         1:       bus.out_ready = 1'($urandom_range(0, 1));
         default: bus.out_ready = 1'b0;
      endcase
   end

   // Monitor: pops an expectation on the first cycle of each result.
   always @(negedge clk) begin
      if (!rst_n) begin
         seen = 1'b0;
      end else if (bus.out_valid) begin
         if (!seen) begin
            if (sb.size() == 0) begin
               check("unexpected_result", 1, 0);
               cur_exp = bus.dout;
            end else begin
               exp_t e;
               e = sb.pop_front();
               cur_exp = e.data;
               check("dout", int'(bus.dout), int'(e.data));
               check("latency", cyc - e.acc, e.lat);
            end
            seen = 1'b1;
         end else begin
            check("dout_hold", int'(bus.dout), int'(cur_exp));
         end
         if (bus.out_ready) seen = 1'b0;
      end
   end

   task automatic issue(input logic [WIDTH-1:0] d, input logic sel, input logic dir,
                        input int amt, input logic [WIDTH-1:0] exp);
      exp_t e;
      bit   ok;
      @(posedge clk);
      #1;
      bus.in_valid    = 1'b1;
      bus.din         = d;
      bus.select      = sel;
      bus.direction   = dir;
      bus.shift_value = SHW'(amt);
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (bus.in_ready) ok = 1'b1;
      end
      if (!ok) begin
         check("accept_timeout", 0, 1);
      end else begin
         e.data = exp;
         e.lat  = amt + 1;
         e.acc  = cyc;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.in_valid    = 1'b0;
      bus.din         = WIDTH'($urandom);
      bus.select      = 1'($urandom);
      bus.direction   = 1'($urandom);
      bus.shift_value = SHW'($urandom);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
      check("drain", sb.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WIDTH-1:0] d;
      logic             s, r;
      int               a;
      cyc             = 0;
      vectors         = 0;
      miscompares     = 0;
      ready_mode      = 0;
      seen            = 1'b0;
      rst_n           = 1'b0;
      bus.in_valid    = 1'b0;
      bus.select      = 1'b0;
      bus.direction   = 1'b0;
      bus.shift_value = '0;
      bus.din         = '0;
      bus.out_ready   = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_in_ready", int'(bus.in_ready), 1);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_dout", int'(bus.dout), 0);
      rst_n = 1'b1;

      issue(4'b1011, 1'b0, 1'b1, 2, 4'b1100);
      issue(4'b1011, 1'b1, 1'b0, 3, 4'b0111);
      issue(4'b1001, 1'b1, 1'b1, 1, 4'b0011);
      issue(4'b0110, 1'b1, 1'b0, 0, 4'b0110);
      issue(4'b0110, 1'b0, 1'b1, 0, 4'b0110);
      wait_drain();

      // Consumer stalls: result must hold and a pending command must wait.
      ready_mode = 2;
      @(posedge clk);
      #1;
      issue(4'b1011, 1'b1, 1'b1, 1, 4'b0111);
      for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
      check("hold_reached_done", int'(bus.out_valid), 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.din      = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_in_ready", int'(bus.in_ready), 0);
         check("hold_out_valid", int'(bus.out_valid), 1);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      ready_mode   = 0;
      repeat (4) @(negedge clk);
      check("hold_released", int'(bus.out_valid), 0);

      // Reset mid-shift discards the command.
      issue(4'b1011, 1'b0, 1'b1, 3, 4'b1000);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", int'(bus.out_valid), 0);
      check("midrst_dout", int'(bus.dout), 0);
      check("midrst_in_ready", int'(bus.in_ready), 1);
      sb.delete();
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      issue(4'b1000, 1'b0, 1'b0, 3, 4'b0001);
      wait_drain();

      ready_mode = 1;
      for (int n = 0; n < 1000; n++) begin
         d = WIDTH'($urandom);
         s = 1'($urandom);
         r = 1'($urandom);
         a = $urandom_range(0, WIDTH - 1);
         issue(d, s, r, a, model(d, s, r, a));
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      ready_mode = 0;
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
